// File: rtl/onehot_sequencer.sv
// rtl/onehot_sequencer.sv - registered N-to-2^N one-hot decoder with handshaked direct select and dwell-timed scan
module onehot_sequencer #(
    parameter int N       = 3,
    parameter int DWELL_W = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 enable,
    input  logic                 mode,
    input  logic                 sel_valid,
    input  logic [N-1:0]         sel,
    output logic                 sel_ready,
    input  logic [DWELL_W-1:0]   dwell,
    output logic [(2**N)-1:0]    D,
    output logic [N-1:0]         index,
    output logic                 wrap
);

    localparam int W = 2**N;

    typedef enum logic [1:0] {IDLE, DIRECT, SCAN} state_t;

    state_t             state;
    logic [DWELL_W-1:0] cnt;
    logic [N-1:0]       index_inc;

    assign index_inc = index + N'(1);

    function automatic logic [W-1:0] onehot(input logic [N-1:0] i);
        logic [W-1:0] r;
        r    = '0;
        r[i] = 1'b1;
        return r;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            D         <= '0;
            index     <= '0;
            cnt       <= '0;
            wrap      <= 1'b0;
            sel_ready <= 1'b1;
        end else begin
            sel_ready <= ~mode;
            wrap      <= 1'b0;
            // Disabled: blank the lines, everything else holds its value.
            if (!enable) begin
                D <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        if (mode) begin
                            state <= SCAN;
                            index <= '0;
                            cnt   <= '0;
                            D     <= onehot(N'(0));
                        end else begin
                            state <= DIRECT;
                            D     <= onehot(index);
                        end
                    end
                    DIRECT: begin
                        // A mode change beats a handshake offered on the same edge.
                        if (mode) begin
                            state <= SCAN;
                            index <= '0;
                            cnt   <= '0;
                            D     <= onehot(N'(0));
                        end else if (sel_valid && sel_ready) begin
                            index <= sel;
                            D     <= onehot(sel);
                        end else begin
                            D <= onehot(index);
                        end
                    end
                    SCAN: begin
                        if (!mode) begin
                            state <= DIRECT;
                            D     <= onehot(index);
                        end else if (cnt >= dwell) begin
                            cnt   <= '0;
                            index <= index_inc;
                            D     <= onehot(index_inc);
                            wrap  <= &index;
                        end else begin
                            cnt <= cnt + 1'b1;
                            D   <= onehot(index);
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_onehot_sequencer.sv
// tb/tb_onehot_sequencer.sv - scoreboard bench for onehot_sequencer (N=3 and N=4 instances)
module tb_onehot_sequencer;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, enable, mode, sel_valid, sel_ready, wrap;
    logic [2:0] sel, index;
    logic [3:0] dwell;
    logic [7:0] d3;

    logic       rst4, en4, mode4, sv4, rdy4, wrap4;
    logic [3:0] sel4, idx4, dwell4;
    logic [15:0] d4;

    onehot_sequencer #(.N(3), .DWELL_W(4)) u3 (
        .clk(clk), .rst(rst), .enable(enable), .mode(mode),
        .sel_valid(sel_valid), .sel(sel), .sel_ready(sel_ready),
        .dwell(dwell), .D(d3), .index(index), .wrap(wrap)
    );

    onehot_sequencer #(.N(4), .DWELL_W(4)) u4 (
        .clk(clk), .rst(rst4), .enable(en4), .mode(mode4),
        .sel_valid(sv4), .sel(sel4), .sel_ready(rdy4),
        .dwell(dwell4), .D(d4), .index(idx4), .wrap(wrap4)
    );

    typedef struct {
        string       tag;
        logic [15:0] d;
        logic [3:0]  idx;
        logic        wrp;
        logic        rdy;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   wraps;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    endtask

    task automatic push(input string tag, input logic [15:0] d, input logic [3:0] idx,
                        input logic wrp, input logic rdy);
        exp_t e;
        e.tag = tag; e.d = d; e.idx = idx; e.wrp = wrp; e.rdy = rdy;
        q.push_back(e);
    endtask

    task automatic pop_check(input bit big);
        exp_t e;
        chk("scoreboard_nonempty", 32'(q.size() > 0), 32'd1);
        if (q.size() == 0) return;
        e = q.pop_front();
        if (big) begin
            chk({e.tag, "_D"},     32'(d4),    32'(e.d));
            chk({e.tag, "_index"}, 32'(idx4),  32'(e.idx));
            chk({e.tag, "_wrap"},  32'(wrap4), 32'(e.wrp));
            chk({e.tag, "_ready"}, 32'(rdy4),  32'(e.rdy));
        end else begin
            chk({e.tag, "_D"},     32'(d3),        32'(e.d));
            chk({e.tag, "_index"}, 32'(index),     32'(e.idx));
            chk({e.tag, "_wrap"},  32'(wrap),      32'(e.wrp));
            chk({e.tag, "_ready"}, 32'(sel_ready), 32'(e.rdy));
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] oh(input int i);
        return 16'(1) << i;
    endfunction

    initial begin
        rst = 1'b1; enable = 1'b0; mode = 1'b0; sel_valid = 1'b0; sel = '0; dwell = '0;
        rst4 = 1'b1; en4 = 1'b1; mode4 = 1'b1; sv4 = 1'b0; sel4 = '0; dwell4 = '0;

        // Reset values while rst is held across a clock edge
        tick();
        enable = 1'b1;
        tick();
        chk("reset_D",     32'(d3),        32'h0);
        chk("reset_index", 32'(index),     32'h0);
        chk("reset_wrap",  32'(wrap),      32'h0);
        chk("reset_ready", 32'(sel_ready), 32'h1);

        // Direct path: single handshake then hold
        rst = 1'b0;
        tick();
        chk("direct_entry_index", 32'(index), 32'h0);
        sel = 3'd5; sel_valid = 1'b1;
        push("hs5", 16'h0020, 4'd5, 1'b0, 1'b1);
        tick(); pop_check(0);
        sel_valid = 1'b0; sel = 3'd1;
        for (int i = 0; i < 3; i++) begin
            push("hold5", 16'h0020, 4'd5, 1'b0, 1'b1);
            tick(); pop_check(0);
        end

        // Direct sweep, back to back
        sel_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            sel = 3'(i);
            push("sweep", oh(i), 4'(i), 1'b0, 1'b1);
            tick(); pop_check(0);
            chk("sweep_onehot", 32'($onehot(d3)), 32'h1);
        end

        // Scan with dwell=2; sel_valid left high must be ignored
        dwell = 4'd2; mode = 1'b1; sel = 3'd3;
        wraps = 0;
        for (int k = 0; k < 50; k++) begin
            push("scan2", oh((k / 3) % 8), 4'((k / 3) % 8), (k > 0) && (k % 24 == 0), 1'b0);
            tick(); pop_check(0);
            if (wrap) wraps++;
        end
        chk("scan2_wrap_count", 32'(wraps), 32'd2);

        // Back to direct (line 0 kept), then fresh scan with dwell=3
        mode = 1'b0; sel_valid = 1'b0;
        push("to_direct", 16'h0001, 4'd0, 1'b0, 1'b1);
        tick(); pop_check(0);
        dwell = 4'd3; mode = 1'b1;
        for (int k = 0; k < 6; k++) begin
            push("scan3", oh(k / 4), 4'(k / 4), 1'b0, 1'b0);
            tick(); pop_check(0);
        end

        // Enable gating: line 1 has been shown 2 of its 4 cycles
        enable = 1'b0;
        for (int k = 0; k < 5; k++) begin
            push("gated", 16'h0000, 4'd1, 1'b0, 1'b0);
            tick(); pop_check(0);
        end
        enable = 1'b1;
        for (int k = 0; k < 2; k++) begin
            push("restored", 16'h0002, 4'd1, 1'b0, 1'b0);
            tick(); pop_check(0);
        end
        for (int line = 2; line < 6; line++) begin
            for (int k = 0; k < 4; k++) begin
                push("scan3_cont", oh(line), 4'(line), 1'b0, 1'b0);
                tick(); pop_check(0);
            end
        end
        for (int k = 0; k < 2; k++) begin
            push("scan3_line6", 16'h0040, 4'd6, 1'b0, 1'b0);
            tick(); pop_check(0);
        end

        // Mode switch at line 6 with sel=2 offered immediately
        mode = 1'b0; sel = 3'd2; sel_valid = 1'b1;
        push("modesw_hold", 16'h0040, 4'd6, 1'b0, 1'b1);
        tick(); pop_check(0);
        push("modesw_accept", 16'h0004, 4'd2, 1'b0, 1'b1);
        tick(); pop_check(0);
        sel_valid = 1'b0;

        // N=4, dwell=0: scan, async reset between edges, wrap every 16 cycles
        rst4 = 1'b0;
        for (int k = 0; k < 10; k++) begin
            push("scan4_pre", oh(k % 16), 4'(k % 16), 1'b0, 1'b0);
            tick(); pop_check(1);
        end
        #3 rst4 = 1'b1;
        #1;
        chk("async_rst_D",     32'(d4),    32'h0);
        chk("async_rst_index", 32'(idx4),  32'h0);
        chk("async_rst_wrap",  32'(wrap4), 32'h0);
        chk("async_rst_ready", 32'(rdy4),  32'h1);
        #2 rst4 = 1'b0;
        wraps = 0;
        for (int k = 0; k < 41; k++) begin
            push("scan4", oh(k % 16), 4'(k % 16), (k > 0) && (k % 16 == 0), 1'b0);
            tick(); pop_check(1);
            if (wrap4) wraps++;
        end
        chk("scan4_wrap_count", 32'(wraps), 32'd2);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/onehot_sequencer.md
# onehot_sequencer

Parametrised, registered successor to the fixed 3-to-8 decoder. It converts an N-bit select into a one-hot 2^N-bit output and adds an autonomous scan mode that walks the active line with a programmable dwell time. A valid/ready handshake is provided for the direct select path. The block sits between control logic and banks of enable or strobe lines, such as memory-bank selects or display-digit multiplexing.

## Interface
Parameters:
- N, default 3: select width; output width is 2^N.
- DWELL_W, default 4: width of the dwell-count input.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- enable  input  1  global enable; when low, all D lines are driven to 0 and state is frozen.
- mode  input  1  0 = direct decode, 1 = scan.
- sel_valid  input  1  the value on sel is offered (direct mode).
- sel  input  N  binary select.
- sel_ready  output  1  block can accept sel; equals (mode == 0) registered.
- dwell  input  DWELL_W  extra cycles held per line in scan mode.
- D  output  2^N  registered one-hot output, or all zero.
- index  output  N  binary index of the current line.
- wrap  output  1  one-cycle pulse when scan wraps from 2^N-1 to 0.

## Operation
- States are IDLE, DIRECT and SCAN.
- Reset:
  - State goes to IDLE.
  - D = 0, index = 0, wrap = 0, sel_ready = 1.
  - Dwell counter cnt = 0.
- IDLE:
  - enable=1 and mode=0: go to DIRECT.
  - enable=1 and mode=1: go to SCAN.
  - D stays 0.
- DIRECT:
  - A handshake fires when sel_valid & sel_ready & enable.
  - On a handshake, index <= sel and D <= one-hot(sel).
  - Without a handshake, D and index hold.
  - mode=1: go to SCAN.
- SCAN:
  - On entry, index <= 0, D <= one-hot(0) and cnt <= 0.
  - Each enabled cycle: if cnt >= dwell, then cnt <= 0 and index <= index+1 (mod 2^N). Otherwise cnt <= cnt+1.
  - Each line is therefore shown for dwell+1 cycles. dwell=0 advances every cycle.
  - dwell is compared live. Lowering it below cnt forces an advance on the next edge.
  - On the advance from index 2^N-1 to 0, wrap = 1 for exactly that cycle, coincident with D = one-hot(0).
  - sel_valid is ignored in SCAN.
  - mode=0: go to DIRECT. index and D keep the last scanned line until a handshake.
- enable low, in any state:
  - D <= 0 on the next edge.
  - index, cnt and state are frozen. No handshake is accepted and wrap = 0.
- enable re-asserted:
  - D <= one-hot(index) on the next edge.
  - Scan resumes with the frozen cnt.
- Invariants:
  - D is always either 0 or exactly one-hot(index).
  - D is 0 only in IDLE or while enable was low in the previous cycle.

## Timing
- All outputs are registered. Input-to-output latency is 1 cycle.
  - Direct: D updates on the edge that completes the handshake.
  - Mode change: takes effect on the next edge. Entering SCAN shows line 0 on that edge.
- sel_ready is registered from mode, so it lags mode by one cycle.
  - A sel_valid in the first direct-mode cycle after leaving SCAN is not accepted.
- Scan period is 2^N × (dwell+1) cycles, and wrap fires once per period.
- Simultaneous events:
  - enable falling on an advance edge: the advance is suppressed.
  - mode change and handshake on the same edge: the mode change wins and the handshake is dropped.
- Asynchronous reset mid-scan forces all outputs to their reset values immediately. Release is honoured on the next clk edge.

## Test plan
- Reset and direct path:
  - Stimulus: rst pulse, enable=1, mode=0, then sel=5 with sel_valid for one cycle (N=3).
  - Required: D=0 during reset. D=8'b0010_0000 and index=5 one cycle after the handshake, then held.
- Direct sweep:
  - Stimulus: sel 0 to 7 back to back, sel_valid held high.
  - Required: D takes each value from 8'h01 to 8'h80 in consecutive cycles, one-hot every cycle.
- Scan with dwell=2:
  - Stimulus: mode=1.
  - Required: each line is held 3 cycles; wrap pulses every 24 cycles, coincident with D=8'h01.
- Enable gating:
  - Stimulus: enable low at cycle 4 of a scan with dwell=3, held low 5 cycles, then high.
  - Required: D=0 for 5 cycles. The same index is restored and shown for its remaining dwell.
- Mode switch:
  - Stimulus: scan at index 6, mode set to 0, sel=2 offered at once.
  - Required: D stays 8'h40. sel_ready rises one cycle later. sel=2 is accepted only after that, giving D=8'h04.
- Asynchronous reset mid-scan (N=4, dwell=0):
  - Stimulus: rst asserted between clock edges.
  - Required: D=0 and index=0 immediately. wrap pulses every 16 cycles after release.
